// File: rtl/factorial_inverse.sv
// rtl/factorial_inverse.sv - decides whether a value is an exact factorial n! and returns n
module factorial_inverse #(
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] data_in,
    output logic         busy,
    output logic         done,
    output logic         valid,
    output logic [N-1:0] n_out
);

    typedef enum logic [2:0] {IDLE, CHECK, DIV, EVAL, DONE} state_t;

    localparam int CW = $clog2(N) + 1;

    state_t         state, state_next;
    logic [N-1:0]   q;
    logic [N-1:0]   i_div;
    logic [N:0]     rem;
    logic [CW-1:0]  cnt;
    logic           res_valid;
    logic [N-1:0]   res_n;

    logic           accept;
    logic           last_div;
    logic [N:0]     rem_shift;
    logic [N:0]     rem_sub;
    logic           ge;

    // busy still high in the done cycle keeps a start there from being accepted
    assign accept    = (state == IDLE) && start && !busy;
    assign last_div  = (cnt == CW'(N - 1));
    assign rem_shift = {rem[N-1:0], q[N-1]};
    assign ge        = (rem_shift >= {1'b0, i_div});
    assign rem_sub   = rem_shift - {1'b0, i_div};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (accept) state_next = CHECK;
            CHECK: state_next = (q <= N'(1)) ? DONE : DIV;
            DIV:   if (last_div) state_next = EVAL;
            EVAL:  state_next = ((rem != '0) || (q == N'(1))) ? DONE : DIV;
            DONE:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // q doubles as the dividend shift register and collects the quotient bits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q         <= '0;
            i_div     <= '0;
            rem       <= '0;
            cnt       <= '0;
            res_valid <= 1'b0;
            res_n     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            valid     <= 1'b0;
            n_out     <= '0;
        end else begin
            done <= 1'b0;
            if (done) begin
                busy <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        q         <= data_in;
                        i_div     <= N'(2);
                        rem       <= '0;
                        cnt       <= '0;
                        res_valid <= 1'b0;
                        res_n     <= '0;
                        busy      <= 1'b1;
                    end
                end
                CHECK: begin
                    if (q == N'(1)) begin
                        res_valid <= 1'b1;
                        res_n     <= N'(1);
                    end
                end
                DIV: begin
                    rem <= ge ? rem_sub : rem_shift;
                    q   <= {q[N-2:0], ge};
                    cnt <= cnt + CW'(1);
                end
                EVAL: begin
                    if (rem == '0) begin
                        if (q == N'(1)) begin
                            res_valid <= 1'b1;
                            res_n     <= i_div;
                        end else begin
                            i_div <= i_div + N'(1);
                            rem   <= '0;
                            cnt   <= '0;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b1;
                    valid <= res_valid;
                    n_out <= res_n;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_factorial_inverse.sv
// tb/tb_factorial_inverse.sv - directed vector bench for factorial_inverse
module tb_factorial_inverse;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] data_in;
    logic        busy;
    logic        done;
    logic        valid;
    logic [15:0] n_out;

    int tests_run;
    int tests_failed;

    typedef struct {
        logic [15:0] data;
        logic        exp_valid;
        logic [15:0] exp_n;
        int          lat;
    } vec_t;

    vec_t vecs[12];

    factorial_inverse #(.N(16)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .data_in (data_in),
        .busy    (busy),
        .done    (done),
        .valid   (valid),
        .n_out   (n_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Starts one operation; edge 0 is the edge that samples start.
    task automatic run_op(input logic [15:0] d, input logic ev, input logic [15:0] en,
                          input int lat, input int glitch, input string nm);
        int          edges;
        logic        prev_v;
        logic [15:0] prev_n;
        logic        busy_ok;
        logic        hold_ok;
        @(negedge clk);
        start   = 1'b1;
        data_in = d;
        @(posedge clk);
        #1;
        start   = 1'b0;
        data_in = 16'(~d);
        prev_v  = valid;
        prev_n  = n_out;
        busy_ok = busy;
        hold_ok = 1'b1;
        edges   = 0;
        while (edges < 300) begin
            @(posedge clk);
            #1;
            edges++;
            if (edges == glitch) begin
                start   = 1'b1;
                data_in = 16'd7;
            end else if (edges == glitch + 1) begin
                start = 1'b0;
            end
            if (done) break;
            if (!busy) busy_ok = 1'b0;
            if (valid !== prev_v || n_out !== prev_n) hold_ok = 1'b0;
        end
        chk({nm, " latency"}, edges, lat);
        chk({nm, " valid"}, {31'd0, valid}, {31'd0, ev});
        chk({nm, " n_out"}, {16'd0, n_out}, {16'd0, en});
        chk({nm, " busy_during"}, {31'd0, busy_ok & busy}, 32'd1);
        chk({nm, " outputs_held"}, {31'd0, hold_ok}, 32'd1);
        @(posedge clk);
        #1;
        chk({nm, " done_pulse"}, {31'd0, done}, 32'd0);
        chk({nm, " busy_drop"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n        = 1'b0;
        start        = 1'b0;
        data_in      = 16'd0;

        vecs[0]  = '{16'd0,     1'b0, 16'd0, 2};
        vecs[1]  = '{16'd1,     1'b1, 16'd1, 2};
        vecs[2]  = '{16'd2,     1'b1, 16'd2, 19};
        vecs[3]  = '{16'd121,   1'b0, 16'd0, 19};
        vecs[4]  = '{16'd12,    1'b0, 16'd0, 53};
        vecs[5]  = '{16'd120,   1'b1, 16'd5, 70};
        vecs[6]  = '{16'd3,     1'b0, 16'd0, 19};
        vecs[7]  = '{16'd5040,  1'b1, 16'd7, 104};
        vecs[8]  = '{16'd65535, 1'b0, 16'd0, 19};
        vecs[9]  = '{16'd6,     1'b1, 16'd3, 36};
        vecs[10] = '{16'd720,   1'b1, 16'd6, 87};
        vecs[11] = '{16'd40320, 1'b1, 16'd8, 121};

        repeat (2) @(posedge clk);
        #1;
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset done", {31'd0, done}, 32'd0);
        chk("reset valid", {31'd0, valid}, 32'd0);
        chk("reset n_out", {16'd0, n_out}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int k = 0; k < 12; k++) begin
            run_op(vecs[k].data, vecs[k].exp_valid, vecs[k].exp_n, vecs[k].lat, -1,
                   $sformatf("vec%0d", k));
        end

        // Reset during a division, after a valid result is showing
        @(negedge clk);
        start   = 1'b1;
        data_in = 16'd720;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        chk("midrst busy_before", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst busy", {31'd0, busy}, 32'd0);
        chk("midrst done", {31'd0, done}, 32'd0);
        chk("midrst valid", {31'd0, valid}, 32'd0);
        chk("midrst n_out", {16'd0, n_out}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(16'd6, 1'b1, 16'd3, 36, -1, "after_rst");

        // Start during busy is ignored; start right after done is accepted
        run_op(16'd120, 1'b1, 16'd5, 70, 5, "ignored_start");
        run_op(16'd24, 1'b1, 16'd4, 53, -1, "back_to_back");

        // Start held high: relaunches as soon as the block is free again
        @(negedge clk);
        start   = 1'b1;
        data_in = 16'd1;
        begin
            int cnt_done;
            int cyc;
            cnt_done = 0;
            for (cyc = 0; cyc < 12; cyc++) begin
                @(posedge clk);
                #1;
                if (done) cnt_done++;
            end
            chk("held_start done_count", cnt_done, 3);
        end
        start = 1'b0;
        repeat (6) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
